// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Widths and saturation limits shared by the accumulator and
//               its differentiator.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int ACC_W_IN  = 21;
    localparam int ACC_W_OUT = 13;

    localparam int ACC_SAT_MAX = (2 ** (ACC_W_OUT - 1)) - 1;
    localparam int ACC_SAT_MIN = -(2 ** (ACC_W_OUT - 1));

    function automatic int acc_sat_max(input int w_out);
        return (1 << (w_out - 1)) - 1;
    endfunction

    function automatic int acc_sat_min(input int w_out);
        return -(1 << (w_out - 1));
    endfunction

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_differentiator_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_differentiator_if
// Description : Sample-in / difference-out bundle of the differentiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_differentiator_if
    import acc_pkg::*;
#(
    parameter int W_IN  = ACC_W_IN,
    parameter int W_OUT = ACC_W_OUT
);

    logic                    ce;
    logic signed [W_IN-1:0]  x;
    logic signed [W_OUT-1:0] y;
    logic                    y_valid;
    logic                    ovf;
    logic                    ovf_sticky;

    modport master (
        output ce,
        output x,
        input  y,
        input  y_valid,
        input  ovf,
        input  ovf_sticky
    );

    modport slave (
        input  ce,
        input  x,
        output y,
        output y_valid,
        output ovf,
        output ovf_sticky
    );

endinterface : acc_differentiator_if
`default_nettype wire

// File: rtl/acc_diff_delay.sv
`default_nettype none
// ============================================================================
// Module      : acc_diff_delay
// Description : DEPTH-deep shift register of past samples; emits the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_diff_delay #(
    parameter int W     = 21,
    parameter int DEPTH = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         en,
    input  wire logic [W-1:0] din,
    output logic      [W-1:0] dout
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else if (en) begin
            r_sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign dout = r_sr[DEPTH-1];

endmodule : acc_diff_delay
`default_nettype wire

// File: rtl/acc_differentiator.sv
`default_nettype none
// ============================================================================
// Module      : acc_differentiator
// Description : Comb/decimator y = x[k] - x[k-M] with saturation, undoing the
//               running-sum accumulator (R=1, M=1) or forming a CIC comb.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_differentiator
    import acc_pkg::*;
#(
    parameter int W_IN  = ACC_W_IN,
    parameter int W_OUT = ACC_W_OUT,
    parameter int R     = 1,
    parameter int M     = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    acc_differentiator_if.slave bus
);

    localparam logic signed [W_IN-1:0] c_SAT_MAX = W_IN'(acc_sat_max(W_OUT));
    localparam logic signed [W_IN-1:0] c_SAT_MIN = W_IN'(acc_sat_min(W_OUT));

    generate
        if (R < 1) begin : g_chk_r
            $error("acc_differentiator: R must be >= 1");
        end
        if ((M < 1) || (M > 4)) begin : g_chk_m
            $error("acc_differentiator: M must be in 1..4");
        end
        if (W_IN < W_OUT) begin : g_chk_w
            $error("acc_differentiator: W_IN must be >= W_OUT");
        end
    endgenerate

    logic                    w_capture;
    logic signed [W_IN-1:0]  w_hist;
    logic signed [W_IN-1:0]  w_diff;
    logic                    w_hi;
    logic                    w_lo;
    logic                    w_ovf;
    logic signed [W_OUT-1:0] w_sat;

    logic signed [W_OUT-1:0] r_y;
    logic                    r_valid;
    logic                    r_ovf;
    logic                    r_sticky;

    // Decimation phase: a capture happens on the last enabled sample of each group of R.
    generate
        if (R == 1) begin : g_no_phase
            assign w_capture = bus.ce;
        end else begin : g_phase
            localparam int c_PH_W = $clog2(R);
            localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(R - 1);

            logic [c_PH_W-1:0] r_phase;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_phase <= '0;
                end else if (bus.ce) begin
                    r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
                end
            end

            assign w_capture = bus.ce && (r_phase == c_PH_LAST);
        end
    endgenerate

    acc_diff_delay #(
        .W     (W_IN),
        .DEPTH (M)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (w_capture),
        .din  (bus.x),
        .dout (w_hist)
    );

    // Modular subtraction makes accumulator wrap-around transparent.
    assign w_diff = bus.x - w_hist;
    assign w_hi   = (w_diff > c_SAT_MAX);
    assign w_lo   = (w_diff < c_SAT_MIN);
    assign w_ovf  = w_hi || w_lo;
    assign w_sat  = w_hi ? c_SAT_MAX[W_OUT-1:0] :
                    w_lo ? c_SAT_MIN[W_OUT-1:0] :
                           w_diff[W_OUT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_ovf   <= w_capture && w_ovf;
            if (w_capture) begin
                r_y      <= w_sat;
                r_sticky <= r_sticky || w_ovf;
            end
        end
    end

    assign bus.y          = r_y;
    assign bus.y_valid    = r_valid;
    assign bus.ovf        = r_ovf;
    assign bus.ovf_sticky = r_sticky;

endmodule : acc_differentiator
`default_nettype wire

// File: doc/acc_differentiator.md
Name: acc_differentiator

Overview:
- Inverse of the accumulator: consumes the 21-bit signed running sum and recovers the per-sample increments as y[k] = x[k] - x[k-M], with optional decimation by R.
- With R=1 and M=1 it exactly undoes the accumulator, recovering the 13-bit `add` stream.
- With R>1 it acts as the comb/decimate half of an integrator-comb (CIC) chain placed after the accumulator.

Parameters:
- W_IN, 21, input width; must equal the accumulator output width.
- W_OUT, 13, output width; must equal the accumulator input width.
- R, 1, decimation ratio (>=1); one output per R enabled input samples.
- M, 1, differential delay in decimated samples (1..4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ce  input  1  clock enable; an input sample is taken only when ce=1
- x  input  W_IN signed  accumulator output
- y  output  W_OUT signed  registered, saturated difference
- y_valid  output  1  one-cycle strobe; y is new this cycle
- ovf  output  1  saturation occurred on the current y; qualified by y_valid
- ovf_sticky  output  1  set on any saturation; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge, overrides ce):
  - y=0, y_valid=0, ovf=0, ovf_sticky=0.
  - Phase counter=0; all M history registers=0.
  - Applies identically mid-operation; the partial decimation phase is discarded.
- Phase counter: ceil(log2(R)) bits, range 0..R-1, advances only on ce=1, wraps R-1 -> 0. When R=1 it is constant 0.
- Capture edge: ce=1 and phase==R-1.
  - d = x - hist[M-1], computed in W_IN bits two's complement, modular (wrap discarded). Accumulator wrap-around is therefore transparent.
  - hist shifts: hist[0] <= x, hist[i] <= hist[i-1].
  - y <= sat(d); y_valid <= 1; ovf <= saturation flag.
  - ovf_sticky <= ovf_sticky | saturation flag.
- Saturation:
  - d > 2^(W_OUT-1)-1 gives y=2^(W_OUT-1)-1 (4095) and flags saturation.
  - d < -2^(W_OUT-1) gives y=-2^(W_OUT-1) (-4096) and flags saturation.
  - Otherwise y is d truncated to W_OUT bits.
- Latency: y/y_valid are updated at the capture edge and visible for the cycle that follows.
- All other edges: y_valid <= 0 and ovf <= 0; y, hist and ovf_sticky hold.
- ce=0: phase, hist and y all frozen; y_valid=0.
- History is zero after reset, so the first M outputs are x-0. This matches an accumulator reset to 0 and is treated as valid; there is no priming suppression.
- Simultaneous rst and capture: reset wins; no strobe.
- Parameter checks (elaboration-time): R>=1; 1<=M<=4; W_IN>=W_OUT.

Decomposition:
- Shared package acc_pkg holds:
  - ACC_W_IN=21 and ACC_W_OUT=13, shared with the accumulator.
  - Saturation limit constants derived from W_OUT.
- One sub-module, acc_diff_delay:
  - M-deep W_IN-wide shift register with shift enable and synchronous reset.
  - Outputs hist[M-1].
- Phase counter, subtractor and saturation logic stay in the top.

Test Plan:
1. R=1, M=1, ce=1: after rst, drive x=4095, 8190, 12285 on three cycles -> y=4095, 4095, 4095 with y_valid high each following cycle; ovf=0.
2. Wrap, R=1, M=1: x=1048575 then x=-1044482 -> second y=4095, ovf=0, proving modular subtraction across accumulator wrap.
3. Saturation, R=1, M=1:
   - x=0 then 10000 -> y=4095, ovf=1, ovf_sticky=1.
   - Then x=10001 -> y=1, ovf=0, ovf_sticky stays 1.
   - x jump of -9000 -> y=-4096, ovf=1.
4. R=4, M=1: x=0,1,2,...,11 with ce=1 -> y_valid only after inputs 3, 7, 11, with y=3, 4, 4 respectively; y holds between strobes.
5. R=4, ce gating: drop ce for 5 cycles at phase 2 while x keeps changing -> no strobe; phase resumes at 2; next strobe is after the 2nd subsequent ce=1 sample, using the x present at that sample.
6. Reset mid-operation, R=4, M=2:
   - Assert rst for one cycle at phase 2 -> y=0, y_valid=0, ovf_sticky=0 next cycle.
   - The next strobe occurs after 4 fresh ce samples, with y = x - 0.
